// File: rtl/bit_packer_pkg.sv
// Shared widths and FSM encoding for the MSB-first bit packer.
package bit_packer_pkg;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 6;
  localparam int ACC_W  = 64;
  localparam int FILL_W = 7;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  // Lengths above one word are treated as a full word.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : l;
  endfunction
endpackage

// File: rtl/bit_packer_length_mask.sv
// Turns a clamped code length (0..32) into a mask of that many LSB ones.
module length_mask
  import bit_packer_pkg::*;
(
  input  logic [LEN_W-1:0]  len,
  output logic [WORD_W-1:0] mask
);
  always_comb begin
    mask = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
  end
endmodule

// File: rtl/bit_packer.sv
// Packs variable-length codes MSB-first into 32-bit words through a 64-bit
// accumulator, with a flush that emits a final, partially filled word.
module bit_packer #(
  parameter int WORD_W = bit_packer_pkg::WORD_W,
  parameter int LEN_W  = bit_packer_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_code,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_last,
  output logic [LEN_W-1:0]  out_nbits
);
  import bit_packer_pkg::*;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_app, placed;
  logic [FILL_W-1:0]   fill_q, fill_d, fill_app;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   out_word_q, out_word_d;
  logic                out_last_q, out_last_d;
  logic [LEN_W-1:0]    out_nbits_q, out_nbits_d;
  logic [LEN_W-1:0]    len_c;
  logic [WORD_W-1:0]   mask, code_m;
  logic                xfer, slot_free, emit_full;

  assign len_c = clamp_len(in_len);

  length_mask u_mask (.len(len_c), .mask(mask));

  assign code_m    = in_code & mask;
  assign in_ready  = (state_q == RUN) && (fill_q <= FILL_W'(32));
  assign xfer      = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;

  // Left-align the code in the top word, then drop it just below the occupied bits.
  assign placed = ({code_m, 32'h0} << (FILL_W'(32) - {1'b0, len_c})) >> fill_q;

  // Emission is decided on the pre-append fill so a word appears one cycle after
  // the transfer that completes it; appended bits land below bit 32 when fill is 32.
  assign emit_full = (state_q == RUN) ? (fill_q >= FILL_W'(32)) : (fill_q > FILL_W'(32));

  always_comb begin
    acc_app  = acc_q;
    fill_app = fill_q;
    if (xfer) begin
      acc_app  = acc_q | placed;
      fill_app = fill_q + {1'b0, len_c};
    end

    state_d     = state_q;
    acc_d       = acc_app;
    fill_d      = fill_app;
    out_valid_d = out_valid_q && !out_ready;
    out_word_d  = out_word_q;
    out_last_d  = out_last_q;
    out_nbits_d = out_nbits_q;

    if (slot_free) begin
      if (emit_full) begin
        out_valid_d = 1'b1;
        out_word_d  = acc_app[ACC_W-1 -: WORD_W];
        out_last_d  = 1'b0;
        out_nbits_d = LEN_W'(32);
        acc_d       = acc_app << 32;
        fill_d      = fill_app - FILL_W'(32);
      end else if (state_q == FLUSH) begin
        out_valid_d = 1'b1;
        out_word_d  = acc_q[ACC_W-1 -: WORD_W];
        out_last_d  = 1'b1;
        out_nbits_d = fill_q[LEN_W-1:0];
        acc_d       = '0;
        fill_d      = '0;
        state_d     = RUN;
      end
    end

    if (state_q == RUN && flush) state_d = FLUSH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      acc_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_last_q  <= 1'b0;
      out_nbits_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_last_q  <= out_last_d;
      out_nbits_q <= out_nbits_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_last  = out_last_q;
  assign out_nbits = out_nbits_q;
endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameter WORD_W, 32, output word width in bits; only 32 is supported.
REQ-002 Parameter LEN_W, 6, width of the code-length field.
REQ-003 Reset is reset_n, asynchronous, active-low; clock is clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  code/length pair is presented.
REQ-007 in_ready  output  1  packer accepts the pair this cycle.
REQ-008 in_code  input  32  code value, right-aligned; bits at or above in_len are ignored.
REQ-009 in_len  input  6  number of valid code bits, 0..32; values 33..63 are treated as 32.
REQ-010 flush  input  1  single-cycle request to emit all buffered bits, ending with a last word.
REQ-011 out_valid  output  1  out_word is valid.
REQ-012 out_ready  input  1  downstream consumes out_word this cycle.
REQ-013 out_word  output  32  packed bits, MSB-first; unused LSBs of a final word are zero.
REQ-014 out_last  output  1  out_word is the final word of a flush.
REQ-015 out_nbits  output  6  count of valid bits in out_word: 32 for non-final words, 0..32 for the final word.

Function
REQ-016 The packer SHALL hold a 64-bit accumulator acc and a fill count of 0..64; occupied bits SHALL be acc[63 -: fill].
REQ-017 A transfer SHALL occur on each in_valid && in_ready clock edge; the code SHALL be masked to len bits and placed at acc[63-fill -: len].
REQ-018 in_ready SHALL equal (state == RUN) && (fill <= 32), combinationally.
REQ-019 len = 0 SHALL be accepted with no change to acc or fill.
REQ-020 The output slot SHALL be free when !out_valid || out_ready.
REQ-021 In RUN, when fill >= 32 and the slot is free, the block SHALL load out_word = acc[63:32], out_last = 0 and out_nbits = 32, then shift acc left by 32 and subtract 32 from fill.
REQ-022 A simultaneous append and emit in one cycle SHALL position the append using the pre-shift fill, giving new fill = fill + len - 32 with no bit lost or duplicated.
REQ-023 Latency SHALL be one cycle from the transfer that completes a 32-bit word to out_valid, when the slot is free.
REQ-024 out_word, out_last and out_nbits SHALL remain stable while out_valid && !out_ready.
REQ-025 The FSM SHALL have two states, RUN and FLUSH; reset enters RUN.
REQ-026 flush sampled in RUN SHALL move the FSM to FLUSH; an input transfer in the same cycle SHALL be included in the flushed data.
REQ-027 flush asserted in FLUSH SHALL be ignored.
REQ-028 In FLUSH, while fill > 32 and the slot is free, the block SHALL emit full non-last words as in REQ-021.
REQ-029 In FLUSH, when fill <= 32 and the slot is free, the block SHALL emit out_word = acc[63:32], out_last = 1 and out_nbits = fill, clear acc and fill, and return to RUN.
REQ-030 A flush with fill = 0 SHALL emit out_word = 0, out_last = 1 and out_nbits = 0.
REQ-031 fill SHALL never exceed 64, and no accepted bit SHALL be dropped.

Reset
REQ-032 Assertion of reset_n SHALL immediately clear out_valid, out_word, out_last, out_nbits, acc and fill, and set the state to RUN, including mid-word and mid-flush.
REQ-033 After reset, in_ready SHALL be 1 and the first accepted bit SHALL be placed at out_word[31] of the next word.

Structure
REQ-034 Package bit_packer_pkg SHALL hold WORD_W, LEN_W, ACC_W = 64 and the FSM state enum (RUN, FLUSH).
REQ-035 Sub-module length_mask SHALL convert a clamped length 0..32 into a 32-bit mask of that many LSB ones, with len 0 giving mask 0; bit_packer SHALL instantiate it once.

Verification
REQ-036 Pushes (0x5,3), (0x1,1), (0x0FFFFFFF,28) with out_ready = 1 -> one word 0xBFFFFFFF, out_nbits 32, out_last 0.
REQ-037 Eight pushes of (0xFFFFFFF0,4) -> out_word 0x00000000, which checks the masking.
REQ-038 Push (0x3,2) then flush -> out_word 0xC0000000, out_last 1, out_nbits 2, followed by in_ready 1 in RUN.
REQ-039 With out_ready = 0, pushes of 0x12345678, 0x9ABCDEF0 and 0x0F0F0F0F (len 32) are accepted and a 4th push stalls with in_ready 0 -> out_word holds 0x12345678 until out_ready = 1, then the words emerge in order.
REQ-040 A flush at fill 0 -> out_word 0, out_last 1, out_nbits 0; a push of (0xABC,0) causes no fill change.
REQ-041 Asserting reset_n low with fill = 17 and out_valid = 1 -> all outputs 0 at once and in_ready 1; a following push of (0x1,1) then flush -> out_word 0x80000000, out_nbits 1.
